// File: rtl/usb_pd_char_arbiter_if.sv
// Character/UART bus between the two CC decoders, the arbiter and the UART transmitter.
// master = decoder/UART side driving characters and flow control; slave = the arbiter.
interface usb_pd_char_arbiter_if;
  logic [7:0] ch0_char;
  logic       ch0_ready;
  logic [7:0] ch1_char;
  logic       ch1_ready;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       clr_ovf;
  logic       ovf0;
  logic       ovf1;
  logic [1:0] grant;

  modport master (
    output ch0_char, ch0_ready, ch1_char, ch1_ready, tx_ready, clr_ovf,
    input  tx_data, tx_valid, ovf0, ovf1, grant
  );

  modport slave (
    input  ch0_char, ch0_ready, ch1_char, ch1_ready, tx_ready, clr_ovf,
    output tx_data, tx_valid, ovf0, ovf1, grant
  );
endinterface

// File: rtl/usb_pd_char_arbiter.sv
// Two-channel USB-PD character arbiter: per-channel FWFT FIFOs feeding one UART,
// packet-granular round-robin grant with optional channel tag and empty-FIFO stall release.
module usb_pd_char_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_char,
  input  logic       pop,
  output logic [7:0] head,
  output logic       nempty,
  output logic       drop
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        full;
  logic        push;

  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign nempty = (wr_ptr_q != rd_ptr_q);
  // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
  assign push   = wr_en && (!full || pop);
  assign drop   = wr_en && full && !pop;
  assign head   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_char;
  end
endmodule

module usb_pd_char_arbiter #(
  parameter int FIFO_DEPTH   = 16,
  parameter int STALL_CYCLES = 2700,
  parameter int TAG_EN       = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  usb_pd_char_arbiter_if.slave bus
);
  localparam int         NUM_CH     = 2;
  localparam logic [7:0] EOP        = 8'h0D;
  localparam logic [15:0] STALL_LAST = 16'(STALL_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_TAG, S_DATA} state_e;

  state_e      state_q, state_d;
  logic        gch_q, gch_d;
  logic        last_q, last_d;
  logic [15:0] stall_q, stall_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d;

  logic [NUM_CH-1:0][7:0] wr_char;
  logic [NUM_CH-1:0][7:0] head;
  logic [NUM_CH-1:0]      wr_en;
  logic [NUM_CH-1:0]      pop;
  logic [NUM_CH-1:0]      nempty;
  logic [NUM_CH-1:0]      drop;

  logic       tx_valid;
  logic [7:0] tx_data;
  logic [1:0] grant;

  assign wr_char = {bus.ch1_char, bus.ch0_char};
  assign wr_en   = {bus.ch1_ready, bus.ch0_ready};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    usb_pd_char_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en[c]),
      .wr_char (wr_char[c]),
      .pop     (pop[c]),
      .head    (head[c]),
      .nempty  (nempty[c]),
      .drop    (drop[c])
    );
  end

  always_comb begin
    state_d  = state_q;
    gch_d    = gch_q;
    last_d   = last_q;
    stall_d  = stall_q;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    grant    = 2'b00;
    pop      = '0;
    unique case (state_q)
      S_IDLE: begin
        stall_d = '0;
        if (|nempty) begin
          // On a tie the channel that did not own the last packet wins.
          gch_d   = (&nempty) ? ~last_q : nempty[1];
          state_d = (TAG_EN != 0) ? S_TAG : S_DATA;
        end
      end
      S_TAG: begin
        grant    = gch_q ? 2'b10 : 2'b01;
        tx_valid = 1'b1;
        tx_data  = 8'h30 + {7'd0, gch_q};
        stall_d  = '0;
        if (bus.tx_ready) state_d = S_DATA;
      end
      S_DATA: begin
        grant    = gch_q ? 2'b10 : 2'b01;
        tx_valid = nempty[gch_q];
        tx_data  = nempty[gch_q] ? head[gch_q] : 8'h00;
        if (tx_valid && bus.tx_ready) begin
          pop[gch_q] = 1'b1;
          stall_d    = '0;
          if (head[gch_q] == EOP) begin
            state_d = S_IDLE;
            last_d  = gch_q;
          end
        end else if (!nempty[gch_q]) begin
          // A silent decoder must not hold the UART forever.
          if (stall_q == STALL_LAST) begin
            state_d = S_IDLE;
            last_d  = gch_q;
            stall_d = '0;
          end else begin
            stall_d = stall_q + 16'd1;
          end
        end else begin
          stall_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ovf_d = bus.clr_ovf ? '0 : ovf_q;
    ovf_d = ovf_d | drop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gch_q   <= 1'b0;
      last_q  <= 1'b1;
      stall_q <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      gch_q   <= gch_d;
      last_q  <= last_d;
      stall_q <= stall_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.tx_valid = tx_valid;
  assign bus.tx_data  = tx_data;
  assign bus.grant    = grant;
  assign bus.ovf0     = ovf_q[0];
  assign bus.ovf1     = ovf_q[1];
endmodule

// File: tb/tb_usb_pd_char_arbiter.sv
// Directed scenarios plus a randomized run, every cycle compared against a queue-based
// packet model of the arbiter (per-channel queues, owner, tag pending, idle counter).
module tb_usb_pd_char_arbiter;
  localparam int DEPTH = 16;
  localparam int STALL = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  usb_pd_char_arbiter_if bus ();
  usb_pd_char_arbiter_if bus_nt ();

  usb_pd_char_arbiter #(.FIFO_DEPTH(DEPTH), .STALL_CYCLES(STALL), .TAG_EN(1)) u_dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  usb_pd_char_arbiter #(.FIFO_DEPTH(DEPTH), .STALL_CYCLES(STALL), .TAG_EN(0)) u_dut_nt (
    .clk (clk), .rst (rst), .bus (bus_nt)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] mq [2][$];
  int         m_own, m_last, m_stall;
  bit         m_tag;
  logic [1:0] m_ovf;

  logic [7:0] out_log [$];
  logic [7:0] exp_q [$];
  bit         prev_hold;
  logic [7:0] prev_data;
  int         cyc = 0;
  int         last_xfer = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_log(input string tag);
    chk({tag, "_len"}, 32'(out_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < out_log.size(); i++)
      chk(tag, 32'(out_log[i]), 32'(exp_q[i]));
  endtask

  task automatic model_reset();
    mq[0].delete();
    mq[1].delete();
    m_own = -1; m_last = 1; m_stall = 0; m_tag = 0; m_ovf = 2'b00;
    prev_hold = 0;
    out_log.delete();
  endtask

  task automatic idle_inputs();
    bus.ch0_char = 8'h00; bus.ch0_ready = 1'b0;
    bus.ch1_char = 8'h00; bus.ch1_ready = 1'b0;
    bus.tx_ready = 1'b0;  bus.clr_ovf = 1'b0;
    bus_nt.ch0_char = 8'h00; bus_nt.ch0_ready = 1'b0;
    bus_nt.ch1_char = 8'h00; bus_nt.ch1_ready = 1'b0;
    bus_nt.tx_ready = 1'b1;  bus_nt.clr_ovf = 1'b0;
  endtask

  // Advance the model across one clock edge using the inputs that were applied.
  task automatic model_step(input bit xfer);
    logic [7:0] b;
    if (m_own >= 0) begin
      if (m_tag) begin
        if (xfer) m_tag = 0;
      end else if (xfer) begin
        b = mq[m_own].pop_front();
        m_stall = 0;
        if (b == 8'h0D) begin m_last = m_own; m_own = -1; end
      end else if (mq[m_own].size() == 0) begin
        m_stall++;
        if (m_stall == STALL) begin m_last = m_own; m_own = -1; m_stall = 0; end
      end else begin
        m_stall = 0;
      end
    end else begin
      if (mq[0].size() > 0 && mq[1].size() > 0) m_own = 1 - m_last;
      else if (mq[0].size() > 0)                m_own = 0;
      else if (mq[1].size() > 0)                m_own = 1;
      m_tag = (m_own >= 0);
      m_stall = 0;
    end
    if (bus.clr_ovf) m_ovf = 2'b00;
    if (bus.ch0_ready) begin
      if (mq[0].size() < DEPTH) mq[0].push_back(bus.ch0_char); else m_ovf[0] = 1'b1;
    end
    if (bus.ch1_ready) begin
      if (mq[1].size() < DEPTH) mq[1].push_back(bus.ch1_char); else m_ovf[1] = 1'b1;
    end
  endtask

  task automatic tick();
    logic       ev;
    logic [7:0] ed;
    logic [1:0] eg;
    #1;
    if (m_own < 0) begin
      ev = 1'b0; ed = 8'h00; eg = 2'b00;
    end else begin
      eg = (m_own == 1) ? 2'b10 : 2'b01;
      if (m_tag) begin
        ev = 1'b1; ed = 8'h30 + 8'(m_own);
      end else begin
        ev = (mq[m_own].size() > 0);
        ed = ev ? mq[m_own][0] : 8'h00;
      end
    end
    chk("tx_valid", 32'(bus.tx_valid), 32'(ev));
    chk("tx_data",  32'(bus.tx_data),  32'(ed));
    chk("grant",    32'(bus.grant),    32'(eg));
    chk("ovf0",     32'(bus.ovf0),     32'(m_ovf[0]));
    chk("ovf1",     32'(bus.ovf1),     32'(m_ovf[1]));
    if (prev_hold) begin
      chk("hold_valid", 32'(bus.tx_valid), 32'(1));
      chk("hold_data",  32'(bus.tx_data),  32'(prev_data));
    end
    if (bus.tx_valid && bus.tx_ready) begin
      out_log.push_back(bus.tx_data);
      last_xfer = cyc;
    end
    prev_hold = bus.tx_valid && !bus.tx_ready;
    prev_data = bus.tx_data;
    @(posedge clk);
    model_step(ev && bus.tx_ready);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    #1;
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'(0));
    chk("rst_tx_data",  32'(bus.tx_data),  32'(0));
    chk("rst_grant",    32'(bus.grant),    32'(0));
    chk("rst_ovf0",     32'(bus.ovf0),     32'(0));
    chk("rst_ovf1",     32'(bus.ovf1),     32'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic send(input int ch, input logic [7:0] c);
    if (ch == 0) begin bus.ch0_char = c; bus.ch0_ready = 1'b1; end
    else         begin bus.ch1_char = c; bus.ch1_ready = 1'b1; end
    tick();
    bus.ch0_ready = 1'b0;
    bus.ch1_ready = 1'b0;
  endtask

  task automatic send2(input logic [7:0] c0, input logic [7:0] c1);
    bus.ch0_char = c0; bus.ch0_ready = 1'b1;
    bus.ch1_char = c1; bus.ch1_ready = 1'b1;
    tick();
    bus.ch0_ready = 1'b0;
    bus.ch1_ready = 1'b0;
  endtask

  task automatic drain(input int max, input bit toggle);
    int n = 0;
    while ((m_own >= 0 || mq[0].size() > 0 || mq[1].size() > 0) && n < max) begin
      if (toggle) bus.tx_ready = ~bus.tx_ready;
      tick();
      n++;
    end
    chk("drain_bound", 32'(n < max), 32'(1));
  endtask

  function automatic logic [7:0] rnd_char();
    if ($urandom % 6 == 0) return 8'h0D;
    return 8'(32'h41 + ($urandom % 26));
  endfunction

  initial begin
    int n;
    int pcts [4];
    logic [7:0] pkt [$];
    pcts = '{90, 10, 60, 35};
    idle_inputs();
    #2;
    do_reset();

    // Single ch0 packet with tag.
    bus.tx_ready = 1'b1;
    send(0, 8'h53); send(0, 8'h54); send(0, 8'h31); send(0, 8'h0D);
    drain(100, 0);
    exp_q = '{8'h30, 8'h53, 8'h54, 8'h31, 8'h0D};
    chk_log("pkt_ch0");

    // Same-cycle tie after reset: ch0 first, then ch1; next tie back to ch0.
    do_reset();
    bus.tx_ready = 1'b1;
    send2(8'h41, 8'h42); send2(8'h0D, 8'h0D);
    drain(100, 0);
    exp_q = '{8'h30, 8'h41, 8'h0D, 8'h31, 8'h42, 8'h0D};
    chk_log("tie1");
    out_log.delete();
    send2(8'h43, 8'h44); send2(8'h0D, 8'h0D);
    drain(100, 0);
    exp_q = '{8'h30, 8'h43, 8'h0D, 8'h31, 8'h44, 8'h0D};
    chk_log("tie2");

    // 17 chars into a 16-deep FIFO while the UART is blocked.
    do_reset();
    for (int i = 0; i < 17; i++) send(1, 8'(8'h61 + i));
    chk("ovf1_set", 32'(bus.ovf1), 32'(1));
    chk("ovf0_clean", 32'(bus.ovf0), 32'(0));
    tick();
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    chk("ovf1_cleared", 32'(bus.ovf1), 32'(0));
    bus.tx_ready = 1'b1;
    drain(200, 0);
    exp_q.delete();
    exp_q.push_back(8'h31);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h61 + i));
    chk_log("ovf_stream");

    // Stalled ch0 packet releases the grant; pending ch1 packet follows.
    do_reset();
    bus.tx_ready = 1'b1;
    send(0, 8'h53); send(0, 8'h54);
    send(1, 8'h58); send(1, 8'h0D);
    n = 0;
    while (bus.grant != 2'b00 && n < 200) begin tick(); n++; end
    chk("stall_gap", 32'(cyc - last_xfer), 32'(STALL + 1));
    drain(200, 0);
    exp_q = '{8'h30, 8'h53, 8'h54, 8'h31, 8'h58, 8'h0D};
    chk_log("stall_stream");

    // tx_ready toggling every cycle during a packet.
    do_reset();
    pkt.delete();
    for (int i = 0; i < 6; i++) pkt.push_back(8'(8'h41 + ($urandom % 26)));
    pkt.push_back(8'h0D);
    foreach (pkt[i]) begin
      bus.tx_ready = ~bus.tx_ready;
      send(0, pkt[i]);
    end
    drain(200, 1);
    exp_q.delete();
    exp_q.push_back(8'h30);
    foreach (pkt[i]) exp_q.push_back(pkt[i]);
    chk_log("toggle_stream");

    // Asynchronous reset with five chars buffered.
    do_reset();
    for (int i = 0; i < 5; i++) send(0, 8'(8'h70 + i));
    #2;
    do_reset();
    chk("post_rst_grant", 32'(bus.grant), 32'(0));
    bus.tx_ready = 1'b1;
    repeat (5) tick();

    // Minimum latency with the tag disabled.
    bus_nt.ch0_char = 8'h5A;
    bus_nt.ch0_ready = 1'b1;
    chk("lat_c0_valid", 32'(bus_nt.tx_valid), 32'(0));
    tick();
    bus_nt.ch0_ready = 1'b0;
    chk("lat_c1_valid", 32'(bus_nt.tx_valid), 32'(0));
    tick();
    chk("lat_c2_valid", 32'(bus_nt.tx_valid), 32'(1));
    chk("lat_c2_data",  32'(bus_nt.tx_data),  32'(8'h5A));
    chk("lat_c2_grant", 32'(bus_nt.grant),    32'(2'b01));

    // Randomized traffic against the model.
    do_reset();
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 750; i++) begin
        bus.ch0_ready = ($urandom % 4) == 0;
        bus.ch0_char  = rnd_char();
        bus.ch1_ready = ($urandom % 4) == 0;
        bus.ch1_char  = rnd_char();
        bus.tx_ready  = ($urandom % 100) < pcts[p];
        bus.clr_ovf   = ($urandom % 50) == 0;
        tick();
      end
    end
    idle_inputs();
    bus.tx_ready = 1'b1;
    drain(3000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/usb_pd_char_arbiter.md
USB_PD_CHAR_ARBITER -- requirements
Module: usb_pd_char_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, per-channel character FIFO depth; power of 2, minimum 2.
REQ-002 Parameter STALL_CYCLES, default 2700, granted-FIFO-empty cycles before the grant is released (100 us at 27 MHz); range 1 to 65535.
REQ-003 Parameter TAG_EN, default 1, 1 = emit a channel tag character before each packet.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 ch0_char  input  8  CC1 decoder ASCII character.
REQ-007 ch0_ready  input  1  CC1 character strobe, one cycle per character.
REQ-008 ch1_char  input  8  CC2 decoder ASCII character.
REQ-009 ch1_ready  input  1  CC2 character strobe, one cycle per character.
REQ-010 tx_ready  input  1  UART transmitter can accept a byte.
REQ-011 tx_data  output  8  byte to the UART transmitter.
REQ-012 tx_valid  output  1  tx_data is valid.
REQ-013 clr_ovf  input  1  clears both overflow flags.
REQ-014 ovf0 / ovf1  output  1  sticky flag: a character was dropped on channel 0 / channel 1.
REQ-015 grant  output  2  one-hot owner of the transmitter (bit0 = ch0, bit1 = ch1); 00 = idle.

Function
REQ-016 Each channel SHALL have a first-word-fall-through FIFO.
- Write on the chN_ready rising clock edge.
- FIFO is non-empty in the cycle after the write.
REQ-017 A write to a full FIFO SHALL drop the character and set ovfN, unless a pop occurs in the same cycle; a same-cycle pop frees a slot and the write succeeds.
REQ-018 A byte transfer SHALL occur only on a clock edge where tx_valid and tx_ready are both 1.
- tx_data and tx_valid stay stable while tx_valid=1 and tx_ready=0.
REQ-019 The state machine SHALL have three states: IDLE, TAG and DATA.
REQ-020 IDLE:
- grant=00, tx_valid=0.
- Exactly one FIFO non-empty: grant that channel.
- Both non-empty: grant the channel other than last_grant (round-robin).
- Next state is TAG if TAG_EN=1, otherwise DATA.
REQ-021 TAG:
- tx_valid=1, tx_data = 8'h30 + channel index ('0' or '1').
- Move to DATA on transfer.
REQ-022 DATA:
- tx_valid = granted FIFO non-empty; tx_data = granted FIFO head.
- Each transfer pops the granted FIFO.
REQ-023 In DATA, transfer of the byte 8'h0D (EOP) SHALL move the state machine to IDLE and update last_grant to the granted channel.
REQ-024 In DATA, a stall counter SHALL count consecutive cycles in which the granted FIFO is empty.
- Reset to 0 by any transfer.
- Reaching STALL_CYCLES: move to IDLE, update last_grant; no byte is emitted.
REQ-025 The non-granted channel SHALL keep filling its FIFO while the other channel holds the grant; its characters are never forwarded mid-packet of the other channel.
REQ-026 clr_ovf=1 SHALL clear ovf0 and ovf1 in the next cycle; an overflow in the same cycle as clr_ovf takes priority and sets the flag.
REQ-027 Minimum latency SHALL be 2 cycles from chN_ready to that channel's character on tx_data when IDLE and TAG_EN=0.
REQ-028 Characters SHALL be forwarded per channel in arrival order with no duplication.

Reset
REQ-029 While rst=1:
- FIFOs empty; state IDLE.
- grant=00, tx_valid=0, tx_data=8'h00.
- ovf0=ovf1=0, stall counter 0, last_grant=ch1, so ch0 wins the first tie.
REQ-030 Reset mid-packet SHALL discard all buffered characters; operation resumes in IDLE on the first edge after rst deasserts.

Verification
REQ-031 Scenario: ch0 sends "S","T","1","0x0D"; tx_ready=1; TAG_EN=1 -> tx bytes 0x30,0x53,0x54,0x31,0x0D; grant=01 throughout, then 00.
REQ-032 Scenario: ch0 and ch1 each receive one char in the same cycle after reset, each packet ending in 0x0D -> ch0 packet emitted first, then ch1 packet (tag 0x31); next tie goes to ch0.
REQ-033 Scenario: tx_ready=0 while 17 chars arrive on ch1 (FIFO_DEPTH=16) -> 16 stored, ovf1=1, ovf0=0; clr_ovf pulse -> ovf1=0 next cycle.
REQ-034 Scenario: ch0 sends "S","T" then nothing -> grant released STALL_CYCLES cycles after the last transfer; pending ch1 data then gets the grant.
REQ-035 Scenario: tx_ready toggles 1/0 every cycle during a packet -> tx_data is stable while stalled; output byte order matches input.
REQ-036 Scenario: rst asserted mid-packet with 5 chars buffered -> tx_valid=0 and grant=00 immediately; FIFOs empty after release.
